// File: rtl/wbc_rst_seq.sv
// Reset sequencer for the sys_clk domain: debounces reset requests, holds all
// stage resets while any request is active, then releases stages in order.
module wbc_rst_seq #(
    parameter int CLKFREQ     = 50000000,
    parameter int NREQ        = 4,
    parameter int DEBOUNCE    = 5,
    parameter int NSTG        = 3,
    parameter int MIN_WIDTH   = 15,
    parameter int STG_DELAY   = 16,
    parameter int RDY_TIMEOUT = 1000000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_mask,
    input  logic [NSTG-1:0] stg_ready,
    output logic [NSTG-1:0] stg_rst,
    output logic            seq_done,
    output logic [NREQ-1:0] cause,
    output logic            rdy_tmo,
    input  logic            cause_clr
);

    localparam int TICK_N  = (CLKFREQ / 1000 > 0) ? CLKFREQ / 1000 : 1;
    localparam int TICK_W  = (TICK_N > 1) ? $clog2(TICK_N) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int MAX_A   = (MIN_WIDTH > STG_DELAY) ? MIN_WIDTH : STG_DELAY;
    localparam int CNT_MAX = (MAX_A > RDY_TIMEOUT) ? MAX_A : RDY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int K_W     = (NSTG > 1) ? $clog2(NSTG) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_N - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  MINW_LAST = CNT_W'(MIN_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'(STG_DELAY - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(NSTG - 1);

    typedef enum logic [2:0] {
        HOLD,
        MINW,
        WAIT,
        DLY,
        DONE
    } state_t;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [NREQ-1:0]   req_p0;
    logic [NREQ-1:0]   req_p1;
    logic [NREQ-1:0]   act;
    logic [NREQ-1:0]   db;
    logic [DB_W-1:0]   db_cnt [NREQ];
    logic              any_req;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [K_W-1:0]    k;
    logic [K_W-1:0]    k_nxt;
    logic [NSTG-1:0]   stg_rst_nxt;
    logic              seq_done_nxt;
    logic              tmo_set;
    logic              rdy_k;

    // Free-running millisecond divider; tick marks the wrap cycle.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Synchroniser stages p0/p1, then debounce: set at once, release after DEBOUNCE quiet ticks.
    assign act     = req_p1 & ~req_mask;
    assign any_req = |db;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            req_p0 <= '0;
            req_p1 <= '0;
            db     <= '0;
            for (int i = 0; i < NREQ; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            req_p0 <= req;
            req_p1 <= req_p0;
            for (int i = 0; i < NREQ; i++) begin
                if (act[i]) begin
                    db[i]     <= 1'b1;
                    db_cnt[i] <= '0;
                end else if (db[i] && tick) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= 1'b0;
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdy_k = 1'b0;
        for (int j = 0; j < NSTG; j++) begin
            if (k == K_W'(j)) begin
                rdy_k = stg_ready[j];
            end
        end
    end

    // Sequencer next state; outputs are computed here and registered below.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        k_nxt        = k;
        stg_rst_nxt  = stg_rst;
        seq_done_nxt = seq_done;
        tmo_set      = 1'b0;
        if (any_req) begin
            state_nxt    = HOLD;
            cnt_nxt      = '0;
            k_nxt        = '0;
            stg_rst_nxt  = '1;
            seq_done_nxt = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    state_nxt = MINW;
                    cnt_nxt   = '0;
                end
                MINW: begin
                    if (cnt == MINW_LAST) begin
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                        k_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (rdy_k) begin
                        state_nxt = DLY;
                        cnt_nxt   = '0;
                    end else if (cnt == TMO_LAST) begin
                        state_nxt = DLY;
                        cnt_nxt   = '0;
                        tmo_set   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DLY: begin
                    if (cnt == DLY_LAST) begin
                        for (int j = 0; j < NSTG; j++) begin
                            if (k == K_W'(j)) begin
                                stg_rst_nxt[j] = 1'b0;
                            end
                        end
                        cnt_nxt = '0;
                        if (k == K_LAST) begin
                            state_nxt    = DONE;
                            seq_done_nxt = 1'b1;
                        end else begin
                            k_nxt     = k + 1'b1;
                            state_nxt = WAIT;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DONE: begin
                    seq_done_nxt = 1'b1;
                end
                default: begin
                    state_nxt = HOLD;
                end
            endcase
        end
    end

    // Registered sequencer outputs; sticky flags let a new set win over a clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= HOLD;
            cnt      <= '0;
            k        <= '0;
            stg_rst  <= '1;
            seq_done <= 1'b0;
            rdy_tmo  <= 1'b0;
            cause    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            k        <= k_nxt;
            stg_rst  <= stg_rst_nxt;
            seq_done <= seq_done_nxt;
            rdy_tmo  <= (rdy_tmo & ~cause_clr) | tmo_set;
            cause    <= (cause_clr ? '0 : cause) | db;
        end
    end

endmodule

// File: tb/tb_wbc_rst_seq.sv
// Bench for wbc_rst_seq: directed scenarios plus randomized traffic, compared
// every cycle with a behavioural model of the sequencing rules.
module tb_wbc_rst_seq;

    localparam int CLKFREQ     = 1000;
    localparam int NREQ        = 4;
    localparam int DEBOUNCE    = 5;
    localparam int NSTG        = 3;
    localparam int MIN_WIDTH   = 15;
    localparam int STG_DELAY   = 16;
    localparam int RDY_TIMEOUT = 100;
    localparam int TICK_N      = CLKFREQ / 1000;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_mask = '0;
    logic [NSTG-1:0] stg_ready = '1;
    logic            cause_clr = 1'b0;
    logic [NSTG-1:0] stg_rst;
    logic            seq_done;
    logic [NREQ-1:0] cause;
    logic            rdy_tmo;

    always #5 sys_clk = ~sys_clk;

    wbc_rst_seq #(
        .CLKFREQ    (CLKFREQ),
        .NREQ       (NREQ),
        .DEBOUNCE   (DEBOUNCE),
        .NSTG       (NSTG),
        .MIN_WIDTH  (MIN_WIDTH),
        .STG_DELAY  (STG_DELAY),
        .RDY_TIMEOUT(RDY_TIMEOUT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .req_mask (req_mask),
        .stg_ready(stg_ready),
        .stg_rst  (stg_rst),
        .seq_done (seq_done),
        .cause    (cause),
        .rdy_tmo  (rdy_tmo),
        .cause_clr(cause_clr)
    );

    // Reference model: requests tracked as "ticks since last active",
    // sequence tracked as (stage number, waiting-or-spacing, elapsed cycles).
    logic [NREQ-1:0] m_p0 = '0, m_p1 = '0, m_db = '0, m_act = '0, m_cause = '0;
    logic [NSTG-1:0] m_rst = '1;
    logic            m_done = 1'b0, m_tmo = 1'b0, m_any = 1'b0, m_tick = 1'b0;
    int              m_quiet [NREQ];
    int              m_tdiv = 0;
    int              m_stage = -2;   // -2 held, -1 minimum width, 0..NSTG-1 stage, NSTG done
    int              m_elapsed = 0;
    bit              m_waiting = 1'b0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_p0 = '0; m_p1 = '0; m_db = '0; m_cause = '0;
            m_rst = '1; m_done = 1'b0; m_tmo = 1'b0;
            for (int i = 0; i < NREQ; i++) m_quiet[i] = DEBOUNCE;
            m_tdiv = 0; m_stage = -2; m_elapsed = 0; m_waiting = 1'b0;
        end else begin
            m_tick  = (m_tdiv == TICK_N - 1);
            m_act   = m_p1 & ~req_mask;
            m_any   = |m_db;
            m_cause = (cause_clr ? '0 : m_cause) | m_db;
            if (cause_clr) m_tmo = 1'b0;
            if (m_any) begin
                m_stage = -2; m_elapsed = 0; m_waiting = 1'b0; m_rst = '1; m_done = 1'b0;
            end else if (m_stage == -2) begin
                m_stage = -1; m_elapsed = 0;
            end else if (m_stage == -1) begin
                m_elapsed++;
                if (m_elapsed == MIN_WIDTH) begin
                    m_stage = 0; m_waiting = 1'b1; m_elapsed = 0;
                end
            end else if (m_stage < NSTG) begin
                m_elapsed++;
                if (m_waiting) begin
                    if (stg_ready[m_stage]) begin
                        m_waiting = 1'b0; m_elapsed = 0;
                    end else if (m_elapsed == RDY_TIMEOUT) begin
                        m_waiting = 1'b0; m_elapsed = 0; m_tmo = 1'b1;
                    end
                end else if (m_elapsed == STG_DELAY) begin
                    m_rst[m_stage] = 1'b0;
                    m_stage++;
                    m_waiting = 1'b1; m_elapsed = 0;
                    if (m_stage == NSTG) m_done = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (m_act[i]) m_quiet[i] = 0;
                else if (m_tick && m_quiet[i] < DEBOUNCE) m_quiet[i]++;
                m_db[i] = (m_quiet[i] < DEBOUNCE);
            end
            m_p1 = m_p0;
            m_p0 = req;
            m_tdiv = m_tick ? 0 : m_tdiv + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int rel_t [NSTG];
    int n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge sys_clk);
        chk({tag, "_trace"}, 32'({stg_rst, seq_done, cause, rdy_tmo}),
            32'({m_rst, m_done, m_cause, m_tmo}));
    endtask

    task automatic run_seq(input string tag, input int limit);
        int c;
        for (int j = 0; j < NSTG; j++) rel_t[j] = -1;
        c = 0;
        while (seq_done !== 1'b1 && c < limit) begin
            cyc(tag);
            c++;
            for (int j = 0; j < NSTG; j++)
                if (stg_rst[j] === 1'b0 && rel_t[j] < 0) rel_t[j] = c;
        end
        chk({tag, "_done"}, 32'(seq_done), 32'(1));
    endtask

    initial begin
        // Reset state
        cyc("rst");
        cyc("rst");
        chk("rst_stg_rst", 32'(stg_rst), 32'(3'b111));
        chk("rst_seq_done", 32'(seq_done), 32'(0));
        chk("rst_cause", 32'(cause), 32'(0));
        chk("rst_rdy_tmo", 32'(rdy_tmo), 32'(0));
        sys_rst = 1'b0;

        // Power-up sequence with all stages ready
        run_seq("t1", 300);
        chk("t1_gap01", 32'(rel_t[1] - rel_t[0]), 32'(1 + STG_DELAY));
        chk("t1_gap12", 32'(rel_t[2] - rel_t[1]), 32'(1 + STG_DELAY));
        chk("t1_stg_rst", 32'(stg_rst), 32'(3'b000));
        chk("t1_cause", 32'(cause), 32'(0));

        // Short request pulse while done: four-edge latency, then re-sequence
        req[2] = 1'b1;
        cyc("t2"); cyc("t2"); cyc("t2");
        chk("t2_before_lat", 32'(stg_rst), 32'(3'b000));
        req[2] = 1'b0;
        cyc("t2");
        chk("t2_latency", 32'(stg_rst), 32'(3'b111));
        chk("t2_not_done", 32'(seq_done), 32'(0));
        run_seq("t2", 300);
        chk("t2_cause", 32'(cause), 32'(4'b0100));

        // Stage 1 never ready: forced release by timeout
        stg_ready = 3'b101;
        req[0] = 1'b1;
        cyc("t3");
        req[0] = 1'b0;
        repeat (4) cyc("t3");
        chk("t3_hold", 32'(seq_done), 32'(0));
        run_seq("t3", 600);
        chk("t3_gap01", 32'(rel_t[1] - rel_t[0]), 32'(RDY_TIMEOUT + STG_DELAY));
        chk("t3_tmo", 32'(rdy_tmo), 32'(1));
        stg_ready = 3'b111;
        cause_clr = 1'b1;
        cyc("t3");
        cause_clr = 1'b0;
        chk("t3_clr_cause", 32'(cause), 32'(0));
        chk("t3_clr_tmo", 32'(rdy_tmo), 32'(0));

        // Bouncing request keeps every stage in reset
        for (int b = 0; b < 20; b++) begin
            req[0] = ((b / 2) % 2 == 0);
            cyc("t4");
            if (b >= 4) chk("t4_bounce_hold", 32'(stg_rst), 32'(3'b111));
        end
        req[0] = 1'b0;
        for (int b = 0; b < 10; b++) begin
            cyc("t4");
            chk("t4_debounce_hold", 32'(stg_rst), 32'(3'b111));
        end
        run_seq("t4", 300);

        // Masked request is ignored until the mask drops
        req_mask = 4'b0010;
        req[1] = 1'b1;
        repeat (20) cyc("t5");
        chk("t5_masked_rst", 32'(stg_rst), 32'(3'b000));
        chk("t5_masked_cause", 32'(cause[1]), 32'(0));
        req_mask = 4'b0000;
        n = 0;
        while (stg_rst !== 3'b111 && n < 4) begin
            cyc("t5");
            n++;
        end
        chk("t5_unmask_hold", 32'(stg_rst), 32'(3'b111));
        req[1] = 1'b0;
        run_seq("t5", 300);
        chk("t5_cause", 32'(cause[1]), 32'(1));

        // Request arriving mid-sequence re-asserts released stages
        req[0] = 1'b1;
        cyc("t6");
        req[0] = 1'b0;
        n = 0;
        while (stg_rst !== 3'b110 && n < 200) begin
            cyc("t6");
            n++;
        end
        chk("t6_stage0_out", 32'(stg_rst), 32'(3'b110));
        repeat (4) cyc("t6");
        req[3] = 1'b1;
        cyc("t6"); cyc("t6"); cyc("t6");
        chk("t6_pre_hold", 32'(stg_rst), 32'(3'b110));
        cyc("t6");
        chk("t6_reassert", 32'(stg_rst), 32'(3'b111));
        req[3] = 1'b0;
        run_seq("t6", 300);
        chk("t6_cause", 32'(cause[3]), 32'(1));

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            cyc("rand");
            sys_rst   = ($urandom_range(0, 1499) == 0);
            cause_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 59) == 0)
                req = req ^ NREQ'(1 << $urandom_range(0, NREQ - 1));
            if ($urandom_range(0, 299) == 0)
                req_mask = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0)
                stg_ready = NSTG'($urandom_range(0, 7));
        end
        sys_rst = 1'b0;
        cause_clr = 1'b0;
        cyc("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
